jtag_mailbox: RTL and testbench

JTAG_MAILBOX -- requirements
Module: jtag_mailbox

---
 rtl/jtag_mailbox_pkg.sv | 14 +
 rtl/mailbox_fifo.sv | 64 ++++++
 rtl/jtag_mailbox.sv | 94 +++++++++
 tb/tb_jtag_mailbox.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_mailbox_pkg.sv
// Shared types and default sizing for the JTAG mailbox.
// Holds the client handshake FSM encoding and the default word width / FIFO depth.
package jtag_mailbox_pkg;

  localparam int unsigned DefWidth     = 32;
  localparam int unsigned DefDepthLog2 = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StGap  = 2'd2
  } hs_state_e;

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output and synchronous flush.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module mailbox_fifo
  import jtag_mailbox_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned DEPTH_LOG2 = DefDepthLog2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned LevelW = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  full, empty, do_push, do_pop;

  // Level never exceeds Depth, so its MSB alone marks full.
  assign full    = level_q[DEPTH_LOG2];
  assign empty   = (level_q == '0);
  assign do_pop  = out_ready && !empty;
  assign do_push = in_valid && (!full || do_pop);

  assign in_ready  = reset_n && !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr_q];
  assign level     = level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      if (do_push && !do_pop) begin
        level_q <= level_q + LevelW'(1);
      end else if (!do_push && do_pop) begin
        level_q <= level_q - LevelW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/jtag_mailbox.sv
// Client req/wr/ack responder bridging two host valid/ready streams through a pair of FIFOs.
// Each transfer is IDLE -> ACK -> GAP, so acks are single-cycle and at least three cycles apart.
module jtag_mailbox
  import jtag_mailbox_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned DEPTH_LOG2 = DefDepthLog2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic                wr,
  input  logic [WIDTH-1:0]    d,
  output logic [WIDTH-1:0]    q,
  output logic                ack,
  input  logic                h_rx_valid,
  input  logic [WIDTH-1:0]    h_rx_data,
  output logic                h_rx_ready,
  output logic                h_tx_valid,
  output logic [WIDTH-1:0]    h_tx_data,
  input  logic                h_tx_ready,
  input  logic                flush,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic [DEPTH_LOG2:0] tx_level
);

  hs_state_e        state_q, state_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] rx_data;
  logic             tx_not_full, rx_not_empty, tx_push, rx_pop;

  mailbox_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_tx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (tx_push),
    .in_data  (d),
    .in_ready (tx_not_full),
    .out_valid(h_tx_valid),
    .out_data (h_tx_data),
    .out_ready(h_tx_ready),
    .level    (tx_level)
  );

  mailbox_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_rx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (h_rx_valid),
    .in_data  (h_rx_data),
    .in_ready (h_rx_ready),
    .out_valid(rx_not_empty),
    .out_data (rx_data),
    .out_ready(rx_pop),
    .level    (rx_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tx_push || rx_pop) state_d = StAck;
      StAck:   state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // The FIFO transfer happens on the edge that enters ACK; req is only looked at in IDLE.
  always_comb begin
    ack     = (state_q == StAck);
    tx_push = (state_q == StIdle) && req && wr && tx_not_full && !flush;
    rx_pop  = (state_q == StIdle) && req && !wr && rx_not_empty && !flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    q_q <= '0;
    else if (rx_pop) q_q <= rx_data;
  end

  assign q = q_q;

endmodule

// File: tb/tb_jtag_mailbox.sv
// Scoreboard bench for jtag_mailbox: expected stream words are queued at issue time and
// checked by a monitor whenever the DUT acks a read or hands a word to the host.
module tb_jtag_mailbox;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, wr, flush;
  logic [31:0] d, q;
  logic        ack;
  logic        h_rx_valid, h_rx_ready;
  logic [31:0] h_rx_data;
  logic        h_tx_valid, h_tx_ready;
  logic [31:0] h_tx_data;
  logic [4:0]  rx_level, tx_level;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_tx[$];
  logic [31:0] exp_rx[$];
  logic [31:0] q_model = 32'h0;
  bit          client_done;

  always #5 clk = ~clk;

  jtag_mailbox dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .wr        (wr),
    .d         (d),
    .q         (q),
    .ack       (ack),
    .h_rx_valid(h_rx_valid),
    .h_rx_data (h_rx_data),
    .h_rx_ready(h_rx_ready),
    .h_tx_valid(h_tx_valid),
    .h_tx_data (h_tx_data),
    .h_tx_ready(h_tx_ready),
    .flush     (flush),
    .rx_level  (rx_level),
    .tx_level  (tx_level)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: read acks must deliver RX words in host order; host pops must see TX in client order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ack && !wr) begin
        if (exp_rx.size() == 0) begin
          total++; bad++;
          $display("FAIL read_q: got %0h expected none (no word outstanding)", q);
        end else begin
          q_model = exp_rx.pop_front();
          chk("read_q", q, q_model);
        end
      end
      if (h_tx_valid && h_tx_ready) begin
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_data: got %0h expected none (no word outstanding)", h_tx_data);
        end else begin
          chk("tx_data", h_tx_data, exp_tx.pop_front());
        end
      end
    end
  end

  task automatic client_xfer(input bit is_wr, input logic [31:0] data, input bit check_lat);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; wr = is_wr; d = data;
    if (is_wr) exp_tx.push_back(data);
    while (n < 500 && !ok) begin
      @(negedge clk);
      n++;
      if (ack) ok = 1'b1;
    end
    chk("xfer_ack", ok, 1);
    if (check_lat) chk("ack_latency", n, 2);
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("ack_single_cycle", ack, 0);
  endtask

  task automatic host_push(input logic [31:0] data);
    int n;
    n = 0;
    while (n < 500 && !h_rx_ready) begin
      @(negedge clk);
      n++;
    end
    chk("host_ready_wait", h_rx_ready, 1);
    @(posedge clk); #1;
    h_rx_valid = 1'b1; h_rx_data = data;
    exp_rx.push_back(data);
    @(posedge clk); #1;
    h_rx_valid = 1'b0;
  endtask

  task automatic drain_tx();
    int n;
    n = 0;
    @(posedge clk); #1;
    h_tx_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (h_tx_valid && n < 100);
    chk("drain_done", h_tx_valid, 0);
    @(posedge clk); #1;
    h_tx_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [31:0] w;
    reset_n = 1'b0; req = 1'b0; wr = 1'b0; d = '0; flush = 1'b0;
    h_rx_valid = 1'b0; h_rx_data = '0; h_tx_ready = 1'b0;
    #3;
    chk("rst_ack", ack, 0);
    chk("rst_q", q, 0);
    chk("rst_tx_valid", h_tx_valid, 0);
    chk("rst_rx_ready", h_rx_ready, 0);
    chk("rst_levels", {rx_level, tx_level}, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_reset", h_rx_ready, 1);

    // Single client write, host not ready.
    client_xfer(1'b1, 32'hA5A5_0001, 1'b1);
    chk("wr_tx_valid", h_tx_valid, 1);
    chk("wr_tx_data", h_tx_data, 32'hA5A5_0001);
    chk("wr_tx_level", tx_level, 1);
    drain_tx();

    // Read against empty RX stalls until the host supplies a word.
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (ack) seen++;
    end
    chk("no_ack_while_empty", seen, 0);
    host_push(32'h0000_00FF);
    seen = 0;
    while (seen < 20 && !ack) begin
      @(negedge clk);
      seen++;
    end
    chk("read_after_push_ack", ack, 1);
    chk("read_after_push_q", q, 32'h0000_00FF);
    chk("read_after_push_level", rx_level, 0);
    @(posedge clk); #1;
    req = 1'b0;

    // Fill TX, stall the 17th write, free one slot.
    for (int i = 0; i < 16; i++) client_xfer(1'b1, 32'h1000_0000 + i, 1'b1);
    chk("tx_full_level", tx_level, 16);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; d = 32'h1000_0010;
    exp_tx.push_back(32'h1000_0010);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack) seen++;
    end
    chk("tx_full_stall", seen, 0);
    chk("tx_full_stall_level", tx_level, 16);
    @(posedge clk); #1;
    h_tx_ready = 1'b1;
    @(posedge clk); #1;
    h_tx_ready = 1'b0;
    seen = 0;
    while (seen < 20 && !ack) begin
      @(negedge clk);
      seen++;
    end
    chk("stalled_write_ack", ack, 1);
    chk("stalled_write_level", tx_level, 16);
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0;
    drain_tx();

    // Randomised traffic in both directions.
    client_done = 1'b0;
    fork
      begin
        int nr, nw;
        nr = 0; nw = 0;
        while (nr < 20 || nw < 20) begin
          if (nw < 20 && (nr >= 20 || $urandom_range(0, 1) == 1)) begin
            client_xfer(1'b1, $urandom, 1'b0);
            nw++;
          end else begin
            client_xfer(1'b0, 32'h0, 1'b0);
            nr++;
          end
        end
        client_done = 1'b1;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          host_push($urandom);
        end
      end
      begin
        while (!client_done) begin
          @(posedge clk); #1;
          h_tx_ready = ($urandom_range(0, 1) == 1);
        end
        h_tx_ready = 1'b0;
      end
    join
    drain_tx();
    chk("rand_levels", {rx_level, tx_level}, 0);
    chk("rand_tx_outstanding", exp_tx.size(), 0);
    chk("rand_rx_outstanding", exp_rx.size(), 0);

    // Full RX: host push and client pop on the same edge.
    for (int i = 0; i < 16; i++) host_push(32'h2000_0000 + i);
    chk("rx_full_level", rx_level, 16);
    chk("rx_full_ready", h_rx_ready, 0);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0;
    h_rx_valid = 1'b1; h_rx_data = 32'h2000_00AA;
    exp_rx.push_back(32'h2000_00AA);
    @(posedge clk); #1;
    h_rx_valid = 1'b0;
    @(negedge clk);
    chk("collide_ack", ack, 1);
    chk("collide_level", rx_level, 16);
    chk("collide_ready", h_rx_ready, 0);
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 16; i++) client_xfer(1'b0, 32'h0, 1'b1);
    chk("collide_drained", rx_level, 0);

    // Flush with words queued both ways; q survives, writes resume.
    for (int i = 0; i < 3; i++) client_xfer(1'b1, 32'h3000_0000 + i, 1'b1);
    host_push(32'h3100_0000);
    host_push(32'h3100_0001);
    chk("pre_flush_tx", tx_level, 3);
    chk("pre_flush_rx", rx_level, 2);
    w = q_model;
    @(posedge clk); #1;
    flush = 1'b1;
    exp_tx.delete();
    exp_rx.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_levels", {rx_level, tx_level}, 0);
    chk("flush_q_kept", q, w);
    chk("flush_tx_valid", h_tx_valid, 0);
    client_xfer(1'b1, 32'h3200_0000, 1'b1);
    chk("post_flush_level", tx_level, 1);
    chk("post_flush_data", h_tx_data, 32'h3200_0000);
    chk("write_keeps_q", q, w);

    // Reset during ACK with five words queued.
    client_xfer(1'b1, 32'h4000_0000, 1'b1);
    client_xfer(1'b1, 32'h4000_0001, 1'b1);
    host_push(32'h4100_0000);
    host_push(32'h4100_0001);
    chk("pre_reset_levels", {rx_level, tx_level}, {5'd2, 5'd3});
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; d = 32'h4000_0002;
    seen = 0;
    while (seen < 20 && !ack) begin
      @(negedge clk);
      seen++;
    end
    chk("pre_reset_ack", ack, 1);
    #2;
    reset_n = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_levels", {rx_level, tx_level}, 0);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_tx_valid", h_tx_valid, 0);
    chk("mid_rst_rx_ready", h_rx_ready, 0);
    req = 1'b0; wr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    client_xfer(1'b1, 32'h5000_0000, 1'b1);
    chk("post_reset_level", tx_level, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
